// File: rtl/bracket_pkg.sv
// Shared constants and state encoding for the bracket stream generator and recogniser.
package bracket_pkg;

  localparam int MAXLEN = 16;

  localparam logic [7:0] OPEN_CH  = 8'h28;
  localparam logic [7:0] CLOSE_CH = 8'h29;
  localparam logic [7:0] TERM_CH  = 8'h3B;
  localparam logic [7:0] IDLE_CH  = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    TERM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bracket_depth_ctr.sv
// Up/down nesting-depth counter; a close at depth zero sets a sticky underflow flag instead of wrapping.
module bracket_depth_ctr #(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr_cnt,
  output logic [DW-1:0] depth,
  output logic          underflow
);

  always_ff @(posedge clk) begin
    if (clr) begin
      depth     <= '0;
      underflow <= 1'b0;
    end else if (clr_cnt) begin
      // Restart and apply the first character's step in the same cycle.
      depth     <= DW'(inc);
      underflow <= dec;
    end else if (inc) begin
      depth <= depth + DW'(1);
    end else if (dec) begin
      if (depth == '0) underflow <= 1'b1;
      else             depth     <= depth - DW'(1);
    end
  end

endmodule

// File: rtl/bracket_stream_tx.sv
// Serialises a packed bracket pattern into ASCII characters followed by a terminator,
// tracking nesting balance so the expected recogniser verdict is known.
//
// state | meaning
// IDLE  | bus idle, waiting for start
// EMIT  | out holds a pattern character
// TERM  | out holds the terminator
// DONE  | one-cycle done pulse, bal_err valid
module bracket_stream_tx #(
  parameter int         MAXLEN   = bracket_pkg::MAXLEN,
  parameter logic [7:0] OPEN_CH  = bracket_pkg::OPEN_CH,
  parameter logic [7:0] CLOSE_CH = bracket_pkg::CLOSE_CH,
  parameter logic [7:0] TERM_CH  = bracket_pkg::TERM_CH,
  parameter logic [7:0] IDLE_CH  = bracket_pkg::IDLE_CH
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       start,
  input  logic [MAXLEN-1:0]          pattern,
  input  logic [$clog2(MAXLEN):0]    len,
  input  logic                       hold,
  output logic [7:0]                 out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       bal_err
);
  import bracket_pkg::*;

  localparam int LW = $clog2(MAXLEN) + 1;

  state_t            state, state_nx;
  logic [MAXLEN-1:0] shadow, shadow_nx;
  logic [LW-1:0]     len_sh, len_nx;
  logic [LW-1:0]     index, index_nx;
  logic [7:0]        out_nx;
  logic              valid_nx, busy_nx, done_nx, bal_nx;
  logic              inc, dec, clr_cnt;
  logic [LW-1:0]     depth;
  logic              underflow;

  bracket_depth_ctr #(.DW(LW)) u_depth (
    .clk       (clk),
    .clr       (clr),
    .inc       (inc),
    .dec       (dec),
    .clr_cnt   (clr_cnt),
    .depth     (depth),
    .underflow (underflow)
  );

  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    len_nx    = len_sh;
    index_nx  = index;
    out_nx    = out;
    valid_nx  = out_valid;
    busy_nx   = busy;
    done_nx   = done;
    bal_nx    = bal_err;
    inc       = 1'b0;
    dec       = 1'b0;
    clr_cnt   = 1'b0;
    if (!hold) begin
      case (state)
        IDLE: begin
          out_nx   = IDLE_CH;
          valid_nx = 1'b0;
          busy_nx  = 1'b0;
          done_nx  = 1'b0;
          if (start) begin
            len_nx   = (len > LW'(MAXLEN)) ? LW'(MAXLEN) : len;
            bal_nx   = 1'b0;
            clr_cnt  = 1'b1;
            busy_nx  = 1'b1;
            valid_nx = 1'b1;
            // The first character goes out straight from the input so it appears next cycle.
            if (len_nx == '0) begin
              state_nx  = TERM;
              out_nx    = TERM_CH;
              index_nx  = '0;
              shadow_nx = pattern;
            end else begin
              state_nx  = EMIT;
              out_nx    = pattern[MAXLEN-1] ? OPEN_CH : CLOSE_CH;
              inc       = pattern[MAXLEN-1];
              dec       = !pattern[MAXLEN-1];
              index_nx  = LW'(1);
              shadow_nx = {pattern[MAXLEN-2:0], 1'b0};
            end
          end
        end
        EMIT: begin
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
          if (index == len_sh) begin
            state_nx = TERM;
            out_nx   = TERM_CH;
          end else begin
            out_nx    = shadow[MAXLEN-1] ? OPEN_CH : CLOSE_CH;
            inc       = shadow[MAXLEN-1];
            dec       = !shadow[MAXLEN-1];
            index_nx  = index + LW'(1);
            shadow_nx = {shadow[MAXLEN-2:0], 1'b0};
          end
        end
        TERM: begin
          state_nx = DONE;
          out_nx   = IDLE_CH;
          valid_nx = 1'b0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          bal_nx   = underflow || (depth != '0);
        end
        DONE: begin
          state_nx = IDLE;
          out_nx   = IDLE_CH;
          valid_nx = 1'b0;
          busy_nx  = 1'b0;
          done_nx  = 1'b0;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      shadow    <= '0;
      len_sh    <= '0;
      index     <= '0;
      out       <= IDLE_CH;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bal_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      shadow    <= shadow_nx;
      len_sh    <= len_nx;
      index     <= index_nx;
      out       <= out_nx;
      out_valid <= valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      bal_err   <= bal_nx;
    end
  end

endmodule

// File: tb/tb_bracket_stream_tx.sv
// Directed bench for bracket_stream_tx: character sequences, verdicts, hold, clr and restart.
module tb_bracket_stream_tx;

  logic        clk = 1'b0;
  logic        clr, start, hold;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [7:0]  out;
  logic        out_valid, busy, done, bal_err;

  int passed = 0;
  int total  = 0;

  bracket_stream_tx dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .hold      (hold),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .bal_err   (bal_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] p, input logic [4:0] l);
    pattern = p;
    len     = l;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    total++;
    if (out !== 8'h00) $display("FAIL reset_out got %h want 00", out); else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++;
    if (bal_err !== 1'b0) $display("FAIL reset_bal_err got %b want 0", bal_err); else passed++;
  endtask

  task automatic test_balanced();
    logic [7:0] exp [5] = '{8'h28, 8'h28, 8'h29, 8'h29, 8'h3B};
    pulse_start(16'b1100_0000_0000_0000, 5'd4);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, busy, out} !== {2'b11, exp[i]})
        $display("FAIL balanced_char%0d got v=%b b=%b %h want v=1 b=1 %h", i, out_valid, busy, out, exp[i]);
      else passed++;
      tick();
    end
    total++;
    if ({done, bal_err, busy, out_valid, out} !== {4'b1000, 8'h00})
      $display("FAIL balanced_done got d=%b e=%b b=%b v=%b %h want d=1 e=0 b=0 v=0 00",
               done, bal_err, busy, out_valid, out);
    else passed++;
    tick();
    total++;
    if ({done, busy} !== 2'b00) $display("FAIL balanced_idle got d=%b b=%b want 00", done, busy);
    else passed++;
  endtask

  task automatic test_underflow();
    logic [7:0] exp [3] = '{8'h29, 8'h28, 8'h3B};
    pulse_start(16'b0100_0000_0000_0000, 5'd2);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, out} !== {1'b1, exp[i]})
        $display("FAIL underflow_char%0d got v=%b %h want v=1 %h", i, out_valid, out, exp[i]);
      else passed++;
      tick();
    end
    total++;
    if ({done, bal_err} !== 2'b11) $display("FAIL underflow_verdict got d=%b e=%b want d=1 e=1", done, bal_err);
    else passed++;
    tick();
  endtask

  task automatic test_residual();
    int bad = 0;
    pulse_start(16'hFFFF, 5'd16);
    for (int i = 0; i < 16; i++) begin
      if ({out_valid, out} !== {1'b1, 8'h28}) bad++;
      tick();
    end
    total++;
    if (bad != 0) $display("FAIL residual_opens got %0d bad chars want 0", bad); else passed++;
    total++;
    if ({out_valid, out, done} !== {1'b1, 8'h3B, 1'b0})
      $display("FAIL residual_term got v=%b %h d=%b want v=1 3b d=0", out_valid, out, done);
    else passed++;
    tick();
    total++;
    if ({done, bal_err} !== 2'b11)
      $display("FAIL residual_done18 got d=%b e=%b want d=1 e=1", done, bal_err);
    else passed++;
    tick();
  endtask

  task automatic test_empty_and_saturation();
    int bad = 0;
    pulse_start(16'hFFFF, 5'd0);
    total++;
    if ({out_valid, busy, out} !== {2'b11, 8'h3B})
      $display("FAIL empty_term got v=%b b=%b %h want v=1 b=1 3b", out_valid, busy, out);
    else passed++;
    tick();
    total++;
    if ({done, bal_err} !== 2'b10) $display("FAIL empty_done got d=%b e=%b want d=1 e=0", done, bal_err);
    else passed++;
    tick();
    pulse_start(16'hFF00, 5'd20);
    for (int i = 0; i < 16; i++) begin
      if ({out_valid, out} !== {1'b1, (i < 8) ? 8'h28 : 8'h29}) bad++;
      tick();
    end
    total++;
    if (bad != 0) $display("FAIL sat_chars got %0d bad chars want 0", bad); else passed++;
    total++;
    if ({out_valid, out} !== {1'b1, 8'h3B}) $display("FAIL sat_term got v=%b %h want v=1 3b", out_valid, out);
    else passed++;
    tick();
    total++;
    if ({done, bal_err} !== 2'b10) $display("FAIL sat_done got d=%b e=%b want d=1 e=0", done, bal_err);
    else passed++;
    tick();
  endtask

  task automatic test_hold();
    logic [7:0] tail [3] = '{8'h28, 8'h29, 8'h3B};
    hold = 1'b1;
    pattern = 16'h8000;
    len = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    hold = 1'b0;
    total++;
    if ({busy, out_valid} !== 2'b00) $display("FAIL hold_idle_start got b=%b v=%b want 00", busy, out_valid);
    else passed++;
    pulse_start(16'hA000, 5'd4);
    total++;
    if (out !== 8'h28) $display("FAIL hold_char0 got %h want 28", out); else passed++;
    tick();
    total++;
    if (out !== 8'h29) $display("FAIL hold_char1 got %h want 29", out); else passed++;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({out_valid, out} !== {1'b1, 8'h29})
        $display("FAIL hold_frozen%0d got v=%b %h want v=1 29", i, out_valid, out);
      else passed++;
    end
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) start = 1'b1;
      if (i == 1) start = 1'b0;
      total++;
      if ({out_valid, out} !== {1'b1, tail[i]})
        $display("FAIL hold_tail%0d got v=%b %h want v=1 %h", i, out_valid, out, tail[i]);
      else passed++;
    end
    tick();
    total++;
    if ({done, bal_err} !== 2'b10) $display("FAIL hold_done got d=%b e=%b want d=1 e=0", done, bal_err);
    else passed++;
    tick();
    total++;
    if ({busy, out_valid} !== 2'b00) $display("FAIL hold_ignored_start got b=%b v=%b want 00", busy, out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    pulse_start(16'hF000, 5'd8);
    tick();
    tick();
    total++;
    if (out !== 8'h28) $display("FAIL mid_char2 got %h want 28", out); else passed++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if ({out_valid, busy, done, bal_err, out} !== {4'b0000, 8'h00})
      $display("FAIL mid_cleared got v=%b b=%b d=%b e=%b %h want 0 0 0 0 00",
               out_valid, busy, done, bal_err, out);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      if (done || out_valid) seen_done++;
      tick();
    end
    total++;
    if (seen_done != 0) $display("FAIL mid_silent got %0d active cycles want 0", seen_done); else passed++;
    pulse_start(16'h8000, 5'd2);
    total++;
    if (out !== 8'h28) $display("FAIL mid_restart0 got %h want 28", out); else passed++;
    tick();
    total++;
    if (out !== 8'h29) $display("FAIL mid_restart1 got %h want 29", out); else passed++;
    tick();
    tick();
    total++;
    if ({done, bal_err} !== 2'b10) $display("FAIL mid_restart_done got d=%b e=%b want d=1 e=0", done, bal_err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    // Currently in DONE of the previous string; a start held through DONE is taken in IDLE.
    pattern = 16'h4000;
    len = 5'd2;
    start = 1'b1;
    tick();
    total++;
    if ({busy, out_valid} !== 2'b00) $display("FAIL b2b_done_ignored got b=%b v=%b want 00", busy, out_valid);
    else passed++;
    tick();
    start = 1'b0;
    total++;
    if ({out_valid, out} !== {1'b1, 8'h29}) $display("FAIL b2b_first got v=%b %h want v=1 29", out_valid, out);
    else passed++;
    tick();
    tick();
    total++;
    if (out !== 8'h3B) $display("FAIL b2b_term got %h want 3b", out); else passed++;
    tick();
    total++;
    if ({done, bal_err} !== 2'b11) $display("FAIL b2b_done got d=%b e=%b want d=1 e=1", done, bal_err);
    else passed++;
    tick();
  endtask

  initial begin
    clr = 1'b1;
    start = 1'b0;
    hold = 1'b0;
    pattern = '0;
    len = '0;
    test_reset();
    test_balanced();
    test_underflow();
    test_residual();
    test_empty_and_saturation();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
